// File: rtl/hcsr04_responder_if.sv
// rtl/hcsr04_responder_if.sv - trigger/echo signal bundle between the measuring side and the emulated sensor
interface hcsr04_responder_if;
    logic       trig;
    logic [8:0] dist_cm;
    logic       echo;
    logic       busy;
    logic       short_trig;

    modport master (
        output trig,
        output dist_cm,
        input  echo,
        input  busy,
        input  short_trig
    );

    modport slave (
        input  trig,
        input  dist_cm,
        output echo,
        output busy,
        output short_trig
    );
endinterface

// File: rtl/hcsr04_responder.sv
// rtl/hcsr04_responder.sv - HC-SR04 ultrasonic sensor emulator: trig in, distance-scaled echo pulse out
module hcsr04_responder #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TRIG_MIN_CYC = 500,
    parameter int BURST_CYC    = 10_000,
    parameter int CYC_PER_CM   = 2_900,
    parameter int MAX_CM       = 400,
    parameter int TIMEOUT_CYC  = 1_900_000,
    parameter int HOLDOFF_CYC  = 500_000
) (
    input  logic                clk,
    input  logic                rst,
    hcsr04_responder_if.slave   bus
);

    if (CLK_HZ <= 0) begin : g_bad_clk_hz
        $error("CLK_HZ must be positive");
    end

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG_HI = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam logic [20:0] TRIG_MIN_W = 21'(TRIG_MIN_CYC);
    localparam logic [20:0] BURST_W    = 21'(BURST_CYC);
    localparam logic [20:0] CPC_W      = 21'(CYC_PER_CM);
    localparam logic [20:0] MAX_CM_W   = 21'(MAX_CM);
    localparam logic [20:0] TIMEOUT_W  = 21'(TIMEOUT_CYC);
    localparam logic [20:0] HOLDOFF_W  = 21'(HOLDOFF_CYC);

    logic        trig_s1_q, trig_s2_q, trig_prev_q;
    logic [2:0]  state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [8:0]  dist_q, dist_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        short_q, short_d;

    logic        trig_rise;
    logic [20:0] dist_w;
    logic [20:0] echo_len;

    assign trig_rise = trig_s2_q & ~trig_prev_q;
    assign dist_w    = {12'd0, dist_q};
    // Out-of-range or zero distance behaves like a real sensor with no return: full timeout pulse.
    assign echo_len  = (dist_q != 9'd0 && dist_w <= MAX_CM_W) ? dist_w * CPC_W : TIMEOUT_W;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        short_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_rise) begin
                    state_d = S_TRIG_HI;
                    cnt_d   = 21'd1;
                end
            end
            S_TRIG_HI: begin
                if (trig_s2_q) begin
                    if (cnt_q < TRIG_MIN_W) cnt_d = cnt_q + 21'd1;
                end else if (cnt_q >= TRIG_MIN_W) begin
                    state_d = S_BURST;
                    cnt_d   = 21'd0;
                    dist_d  = bus.dist_cm;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 21'd0;
                    short_d = 1'b1;
                end
            end
            S_BURST: begin
                if (cnt_q == BURST_W - 21'd1) begin
                    state_d = S_ECHO;
                    cnt_d   = 21'd0;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            S_ECHO: begin
                if (cnt_q == echo_len - 21'd1) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = 21'd0;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLDOFF_W - 21'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 21'd0;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 21'd0;
            end
        endcase
        echo_d = (state_d == S_ECHO);
        busy_d = (state_d == S_BURST) || (state_d == S_ECHO) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 21'd0;
            dist_q      <= 9'd0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            trig_s1_q   <= bus.trig;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dist_q      <= dist_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            short_q     <= short_d;
        end
    end

    assign bus.echo       = echo_q;
    assign bus.busy       = busy_q;
    assign bus.short_trig = short_q;

endmodule

// File: tb/tb_hcsr04_responder.sv
// tb/tb_hcsr04_responder.sv - directed self-checking bench for hcsr04_responder with small timing parameters
module tb_hcsr04_responder;

    logic clk;
    logic rst;
    hcsr04_responder_if bus_if ();

    hcsr04_responder #(
        .CLK_HZ       (50_000_000),
        .TRIG_MIN_CYC (5),
        .BURST_CYC    (10),
        .CYC_PER_CM   (3),
        .MAX_CM       (400),
        .TIMEOUT_CYC  (50),
        .HOLDOFF_CYC  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int echo_rises = 0, echo_run = 0, echo_last_w = 0, echo_rise_cyc = 0;
    int busy_rises = 0, busy_run = 0, busy_last_w = 0;
    int short_cnt = 0, short_run = 0, short_last_w = 0;
    logic echo_prev = 1'b0, busy_prev = 1'b0, short_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse statistics sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        echo_prev  <= bus_if.echo;
        busy_prev  <= bus_if.busy;
        short_prev <= bus_if.short_trig;
        if (bus_if.echo && !echo_prev) begin
            echo_rises    <= echo_rises + 1;
            echo_rise_cyc <= cyc;
            echo_run      <= 1;
        end else if (bus_if.echo) echo_run <= echo_run + 1;
        if (!bus_if.echo && echo_prev) echo_last_w <= echo_run;
        if (bus_if.busy && !busy_prev) begin
            busy_rises <= busy_rises + 1;
            busy_run   <= 1;
        end else if (bus_if.busy) busy_run <= busy_run + 1;
        if (!bus_if.busy && busy_prev) busy_last_w <= busy_run;
        if (bus_if.short_trig && !short_prev) begin
            short_cnt <= short_cnt + 1;
            short_run <= 1;
        end else if (bus_if.short_trig) short_run <= short_run + 1;
        if (!bus_if.short_trig && short_prev) short_last_w <= short_run;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int fall_cyc;

    task automatic pulse_trig(input int len);
        bus_if.trig = 1'b1;
        tick(len);
        bus_if.trig = 1'b0;
        fall_cyc = cyc;
    endtask

    int er0, br0, sc0;

    initial begin
        bus_if.trig    = 1'b0;
        bus_if.dist_cm = 9'd0;
        rst = 1'b1;
        tick(3);
        check_eq("reset_echo", int'(bus_if.echo), 0);
        check_eq("reset_busy", int'(bus_if.busy), 0);
        check_eq("reset_short", int'(bus_if.short_trig), 0);
        rst = 1'b0;
        tick(3);

        // Nominal 7 cm: echo 21 cycles, rise 3 sync/fall cycles + 10 burst after trig drop
        bus_if.dist_cm = 9'd7;
        pulse_trig(5);
        tick(100);
        check_eq("nom_echo_count", echo_rises, 1);
        check_eq("nom_echo_width", echo_last_w, 21);
        check_eq("nom_echo_delay", echo_rise_cyc - fall_cyc, 13);
        check_eq("nom_busy_width", busy_last_w, 51);
        check_eq("nom_no_short", short_cnt, 0);

        // Too-short trig
        er0 = echo_rises; br0 = busy_rises;
        pulse_trig(4);
        tick(40);
        check_eq("short_count", short_cnt, 1);
        check_eq("short_width", short_last_w, 1);
        check_eq("short_no_echo", echo_rises, er0);
        check_eq("short_no_busy", busy_rises, br0);

        // No target / out of range / minimum distance
        bus_if.dist_cm = 9'd0;
        pulse_trig(5);
        tick(100);
        check_eq("dist0_width", echo_last_w, 50);
        bus_if.dist_cm = 9'd401;
        pulse_trig(5);
        tick(100);
        check_eq("dist401_width", echo_last_w, 50);
        bus_if.dist_cm = 9'd1;
        pulse_trig(5);
        tick(100);
        check_eq("dist1_width", echo_last_w, 3);

        // Trigs during ECHO and HOLDOFF are dropped
        bus_if.dist_cm = 9'd7;
        er0 = echo_rises;
        pulse_trig(5);
        tick(13);
        check_eq("retrig_in_echo", int'(bus_if.echo), 1);
        pulse_trig(5);
        tick(20);
        check_eq("retrig_in_holdoff", int'(bus_if.busy) & ~int'(bus_if.echo), 1);
        pulse_trig(5);
        tick(60);
        check_eq("retrig_one_echo", echo_rises, er0 + 1);
        pulse_trig(5);
        tick(100);
        check_eq("retrig_second_echo", echo_rises, er0 + 2);

        // Distance change after latch
        bus_if.dist_cm = 9'd7;
        pulse_trig(5);
        tick(6);
        bus_if.dist_cm = 9'd100;
        tick(100);
        check_eq("latched_dist_width", echo_last_w, 21);

        // Reset mid-ECHO
        bus_if.dist_cm = 9'd7;
        pulse_trig(5);
        tick(18);
        check_eq("pre_rst_echo", int'(bus_if.echo), 1);
        er0 = echo_rises;
        rst = 1'b1;
        tick(1);
        check_eq("rst_echo", int'(bus_if.echo), 0);
        check_eq("rst_busy", int'(bus_if.busy), 0);
        rst = 1'b0;
        tick(100);
        check_eq("rst_no_residual", echo_rises, er0);

        // Trig held high: stays in TRIG_HI, then a late fall is still a valid trig
        sc0 = short_cnt;
        bus_if.trig = 1'b1;
        tick(60);
        check_eq("held_no_echo", echo_rises, er0);
        check_eq("held_no_busy", int'(bus_if.busy), 0);
        bus_if.trig = 1'b0;
        tick(100);
        check_eq("held_release_echo", echo_rises, er0 + 1);
        check_eq("held_no_short", short_cnt, sc0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hcsr04_responder.md
HCSR04_RESPONDER -- requirements
Module: hcsr04_responder

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency (informational; all timing is set by the *_CYC parameters).
REQ-002 Parameter TRIG_MIN_CYC, default 500, minimum accepted trig high width in cycles (10 us).
REQ-003 Parameter BURST_CYC, default 10_000, delay from accepted trig fall to echo rise (200 us, 8-cycle 40 kHz burst).
REQ-004 Parameter CYC_PER_CM, default 2_900, echo high cycles per centimetre (58 us/cm).
REQ-005 Parameter MAX_CM, default 400, largest distance reported as a valid target.
REQ-006 Parameter TIMEOUT_CYC, default 1_900_000, echo width for "no target" (38 ms).
REQ-007 Parameter HOLDOFF_CYC, default 500_000, dead time after echo fall during which trig is ignored (10 ms).
REQ-008 clk  input  1  system clock; all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 trig  input  1  asynchronous trigger from the measuring side.
REQ-011 dist_cm  input  9  emulated target distance in cm; 0 means no target.
REQ-012 echo  output  1  registered echo pulse returned to the measuring side.
REQ-013 busy  output  1  high while a measurement cycle is in progress (BURST, ECHO, HOLDOFF).
REQ-014 short_trig  output  1  one-cycle pulse flagging a rejected trig that was too short.

Function
REQ-015 trig shall pass through a 2-flop synchronizer; all edge and width logic uses the synchronized signal (2-cycle input latency).
REQ-016 FSM states: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-017 IDLE: on synchronized trig rising edge -> TRIG_HI, width counter cleared to 1.
REQ-018 TRIG_HI: width counter increments each cycle while trig is high and saturates at TRIG_MIN_CYC.
REQ-019 TRIG_HI on trig fall with width >= TRIG_MIN_CYC: latch dist_cm -> BURST.
REQ-020 TRIG_HI on trig fall with width < TRIG_MIN_CYC: -> IDLE; assert short_trig for exactly 1 cycle.
REQ-021 BURST: lasts exactly BURST_CYC cycles, then -> ECHO.
REQ-022 ECHO: echo is high for exactly N cycles, then -> HOLDOFF; N = latched_dist*CYC_PER_CM if 1 <= latched_dist <= MAX_CM, else N = TIMEOUT_CYC.
REQ-023 Echo width product and counters shall be 21 bits wide, unsigned; 400*2900 = 1_160_000 fits without overflow.
REQ-024 HOLDOFF: lasts exactly HOLDOFF_CYC cycles, then -> IDLE; trig edges in BURST, ECHO and HOLDOFF are ignored and are not queued.
REQ-025 A trig already high on entry to IDLE shall not start a cycle; only a fresh rising edge seen in IDLE does.
REQ-026 Changes on dist_cm after the latch point shall not affect the current echo.
REQ-027 echo and short_trig shall be driven from flops, with no combinational path from any input.
REQ-028 trig held high indefinitely shall keep the FSM in TRIG_HI with no echo.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE; echo=0, busy=0, short_trig=0; all counters, synchronizer flops and latched distance cleared.
REQ-030 rst asserted mid-BURST, mid-ECHO or mid-HOLDOFF shall abort the cycle; echo falls on the next edge; no residual pulse follows after rst deasserts.

Verification (small params: TRIG_MIN_CYC=5, BURST_CYC=10, CYC_PER_CM=3, MAX_CM=400, TIMEOUT_CYC=50, HOLDOFF_CYC=20)
REQ-031 dist_cm=7, trig high 5 cycles -> echo rises 10 cycles after the trig-fall state transition, stays high exactly 21 cycles, busy high through HOLDOFF.
REQ-032 trig high 4 cycles -> no echo, single-cycle short_trig, busy stays 0.
REQ-033 dist_cm=0, then a separate run with dist_cm=401 -> each echo width is exactly 50 cycles.
REQ-034 second trig pulse issued during ECHO and another during HOLDOFF -> ignored; exactly one echo; a new trig after return to IDLE produces a second echo.
REQ-035 dist_cm changed from 7 to 100 during BURST -> echo width remains 21 cycles.
REQ-036 rst pulsed mid-ECHO -> echo=0 and busy=0 on the next edge; no echo until the next valid trig.
